// File: rtl/sym_packer_pkg.sv
// Shared definitions for the symbol packer slice.
// Contents:
//   SYM_W, NSYM, WORD_W, DEPTH   default geometry of the packer and its FIFO
//   clog2_w()                    counter/pointer width helper, never below 1
package sym_packer_pkg;

  localparam int SYM_W  = 2;
  localparam int NSYM   = 4;
  localparam int WORD_W = SYM_W * NSYM;
  localparam int DEPTH  = 4;

  // Width needed to index n items. A single item still gets a 1-bit
  // register, so no zero-width vectors appear anywhere.
  function automatic int clog2_w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   wr_en, wr_data       write request and data
//   rd_en                pop request (ignored while empty)
//   rd_data              head entry; holds the last popped word while empty
//   empty, full, count   occupancy status
module sync_fifo
  import sym_packer_pkg::*;
#(
  parameter int WIDTH = sym_packer_pkg::WORD_W,
  parameter int DEPTH = sym_packer_pkg::DEPTH
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [clog2_w(DEPTH):0]     count
);

  localparam int AW = clog2_w(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // When full, a write is only legal if the head leaves on the same edge;
  // in that case the write lands in the slot being vacated.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Once the FIFO drains, the output keeps showing the last word popped
  // rather than whatever stale entry the read pointer lands on.
  assign rd_data = empty ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      hold_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/sym_packer.sv
// Packs a stream of SYM_W-bit symbols MSB-first into NSYM-symbol words and
// buffers them in a show-ahead FIFO with a valid/ready output.
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   sym_in, sym_valid       symbol stream from the upstream block
//   pack_clr                synchronous clear of partial word and overflow
//   word_out, word_valid    FIFO head and not-empty
//   word_ready              consumer accepts word_out on this edge
//   fifo_cnt                words held
//   overflow                sticky: a completed word was dropped
module sym_packer
  import sym_packer_pkg::*;
#(
  parameter int SYM_W = sym_packer_pkg::SYM_W,
  parameter int NSYM  = sym_packer_pkg::NSYM,
  parameter int DEPTH = sym_packer_pkg::DEPTH
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [SYM_W-1:0]          sym_in,
  input  logic                      sym_valid,
  input  logic                      pack_clr,
  output logic [SYM_W*NSYM-1:0]     word_out,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      overflow
);

  localparam int WORD_W = SYM_W * NSYM;
  localparam int SH_W   = WORD_W - SYM_W;
  localparam int CNT_W  = clog2_w(NSYM);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic              overflow_q, overflow_d;

  logic [WORD_W-1:0] word_new;
  logic              word_done;
  logic              pop;
  logic              fifo_wr;
  logic              fifo_empty;
  logic              fifo_full;

  // The shift register only keeps the first NSYM-1 symbols; the last one
  // comes straight from sym_in on the completing edge.
  assign word_new  = {shreg_q, sym_in};
  assign word_done = sym_valid & ~pack_clr & (cnt_q == CNT_W'(NSYM - 1));
  assign pop       = word_ready & ~fifo_empty;
  assign fifo_wr   = word_done & ~(fifo_full & ~pop);

  always_comb begin
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    overflow_d = overflow_q;
    if (pack_clr) begin
      cnt_d      = '0;
      shreg_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (sym_valid) begin
        shreg_d = SH_W'({shreg_q, sym_in});
        cnt_d   = word_done ? '0 : cnt_q + CNT_W'(1);
      end
      if (word_done && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (fifo_wr),
    .wr_data   (word_new),
    .rd_en     (word_ready),
    .rd_data   (word_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

  assign word_valid = ~fifo_empty;
  assign overflow   = overflow_q;

endmodule
